// File: rtl/sim_sd_responder.sv
// Simulation responder for the sd_rd/sd_wr/sd_ack sector handshake.
// Streams 512-byte sectors between an image-store port and requester buffers.
module sim_sd_responder #(
    parameter int VDNUM     = 2,
    parameter int IMG_AW    = 24,
    parameter int ACK_DELAY = 4,
    parameter int BYTE_GAP  = 1
) (
    input  logic                clk_sys,
    input  logic                reset,
    input  logic [VDNUM-1:0]    sd_rd,
    input  logic [VDNUM-1:0]    sd_wr,
    input  logic [32*VDNUM-1:0] sd_lba,
    output logic [VDNUM-1:0]    sd_ack,
    output logic [8:0]          sd_buff_addr,
    output logic [7:0]          sd_buff_dout,
    input  logic [8*VDNUM-1:0]  sd_buff_din,
    output logic                sd_buff_wr,
    input  logic                mount_strobe,
    input  logic [1:0]          mount_drive,
    input  logic [63:0]         mount_size,
    input  logic                mount_ro,
    output logic [VDNUM-1:0]    img_mounted,
    output logic [63:0]         img_size,
    output logic                img_readonly,
    output logic [1:0]          img_drive,
    output logic [IMG_AW-1:0]   img_addr,
    output logic                img_rd,
    input  logic [7:0]          img_q,
    output logic                img_we,
    output logic [7:0]          img_d
);

    typedef enum logic [3:0] {
        S_IDLE, S_ACKWAIT, S_RD_FETCH, S_RD_PUT,
        S_WR_ADDR, S_WR_WAIT, S_WR_CAP, S_GAP, S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       drv_q, drv_d;
    logic             rd_q, rd_d;
    logic [31:0]      lba_q, lba_d;
    logic [63:0]      size_q, size_d;
    logic             ro_q, ro_d;
    logic [8:0]       idx_q, idx_d;
    logic [15:0]      cnt_q, cnt_d;
    logic [VDNUM-1:0] ack_q, ack_d;
    logic [VDNUM-1:0] mnt_q;
    logic [63:0]      isize_q;
    logic             iro_q;
    logic [63:0]      dsize_q [VDNUM];
    logic [VDNUM-1:0] dro_q;

    logic       valid;
    logic       byte_end;
    logic       next_byte;
    logic [7:0] din_sel;

    // Partial trailing sectors count as out of range.
    assign valid = {32'd0, lba_q} < (size_q >> 9);

    assign sd_ack       = ack_q;
    assign img_mounted  = mnt_q;
    assign img_size     = isize_q;
    assign img_readonly = iro_q;
    assign img_drive    = drv_q;

    always_comb begin
        din_sel = 8'd0;
        for (int n = 0; n < VDNUM; n++) begin
            if (drv_q == 2'(n)) din_sel = sd_buff_din[8*n +: 8];
        end
    end

    always_comb begin
        state_d      = state_q;
        drv_d        = drv_q;
        rd_d         = rd_q;
        lba_d        = lba_q;
        size_d       = size_q;
        ro_d         = ro_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        ack_d        = ack_q;
        byte_end     = 1'b0;
        next_byte    = 1'b0;
        sd_buff_addr = 9'd0;
        sd_buff_dout = 8'd0;
        sd_buff_wr   = 1'b0;
        img_addr     = '0;
        img_rd       = 1'b0;
        img_we       = 1'b0;
        img_d        = 8'd0;
        unique case (state_q)
            S_IDLE: begin
                // Downward scan so the lowest requesting drive wins.
                for (int n = VDNUM - 1; n >= 0; n--) begin
                    if (sd_rd[n] | sd_wr[n]) begin
                        drv_d   = 2'(n);
                        rd_d    = sd_rd[n];
                        lba_d   = sd_lba[32*n +: 32];
                        size_d  = dsize_q[n];
                        ro_d    = dro_q[n];
                        cnt_d   = 16'd0;
                        state_d = S_ACKWAIT;
                    end
                end
            end
            S_ACKWAIT: begin
                if (cnt_q == 16'(ACK_DELAY - 1)) begin
                    for (int n = 0; n < VDNUM; n++) begin
                        ack_d[n] = (drv_q == 2'(n));
                    end
                    idx_d   = 9'd0;
                    state_d = rd_q ? S_RD_FETCH : S_WR_ADDR;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_RD_FETCH: begin
                sd_buff_addr = idx_q;
                img_addr     = IMG_AW'({lba_q, idx_q});
                img_rd       = valid;
                state_d      = S_RD_PUT;
            end
            S_RD_PUT: begin
                sd_buff_addr = idx_q;
                sd_buff_dout = valid ? img_q : 8'd0;
                sd_buff_wr   = 1'b1;
                byte_end     = 1'b1;
            end
            S_WR_ADDR: begin
                sd_buff_addr = idx_q;
                state_d      = S_WR_WAIT;
            end
            S_WR_WAIT: begin
                sd_buff_addr = idx_q;
                state_d      = S_WR_CAP;
            end
            S_WR_CAP: begin
                sd_buff_addr = idx_q;
                img_addr     = IMG_AW'({lba_q, idx_q});
                img_d        = din_sel;
                img_we       = valid & ~ro_q;
                byte_end     = 1'b1;
            end
            S_GAP: begin
                sd_buff_addr = idx_q;
                if (cnt_q == 16'(BYTE_GAP - 1)) next_byte = 1'b1;
                else cnt_d = cnt_q + 16'd1;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (byte_end) begin
            if (BYTE_GAP > 0) begin
                cnt_d   = 16'd0;
                state_d = S_GAP;
            end else begin
                next_byte = 1'b1;
            end
        end
        if (next_byte) begin
            if (idx_q == 9'd511) begin
                ack_d   = '0;
                state_d = S_DONE;
            end else begin
                idx_d   = idx_q + 9'd1;
                state_d = rd_q ? S_RD_FETCH : S_WR_ADDR;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q <= S_IDLE;
            drv_q   <= 2'd0;
            rd_q    <= 1'b0;
            lba_q   <= 32'd0;
            size_q  <= 64'd0;
            ro_q    <= 1'b0;
            idx_q   <= 9'd0;
            cnt_q   <= 16'd0;
            ack_q   <= '0;
            mnt_q   <= '0;
            isize_q <= 64'd0;
            iro_q   <= 1'b0;
            dro_q   <= '0;
            for (int n = 0; n < VDNUM; n++) dsize_q[n] <= 64'd0;
        end else begin
            state_q <= state_d;
            drv_q   <= drv_d;
            rd_q    <= rd_d;
            lba_q   <= lba_d;
            size_q  <= size_d;
            ro_q    <= ro_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            mnt_q   <= '0;
            // Per-drive copies only; an in-flight transfer keeps size_q/ro_q.
            for (int n = 0; n < VDNUM; n++) begin
                if (mount_strobe && mount_drive == 2'(n)) begin
                    dsize_q[n] <= mount_size;
                    dro_q[n]   <= mount_ro;
                    mnt_q[n]   <= 1'b1;
                    isize_q    <= mount_size;
                    iro_q      <= mount_ro;
                end
            end
        end
    end

endmodule

// File: tb/tb_sim_sd_responder.sv
// Randomised self-checking bench for sim_sd_responder with an image-store
// model and registered requester buffers.
module tb_sim_sd_responder;

    localparam int VDNUM = 2;

    logic              clk_sys = 1'b0;
    logic              reset = 1'b1;
    logic [VDNUM-1:0]  sd_rd = '0;
    logic [VDNUM-1:0]  sd_wr = '0;
    logic [63:0]       sd_lba = '0;
    logic [VDNUM-1:0]  sd_ack;
    logic [8:0]        sd_buff_addr;
    logic [7:0]        sd_buff_dout;
    logic [15:0]       sd_buff_din;
    logic              sd_buff_wr;
    logic              mount_strobe = 1'b0;
    logic [1:0]        mount_drive = '0;
    logic [63:0]       mount_size = '0;
    logic              mount_ro = 1'b0;
    logic [VDNUM-1:0]  img_mounted;
    logic [63:0]       img_size;
    logic              img_readonly;
    logic [1:0]        img_drive;
    logic [23:0]       img_addr;
    logic              img_rd;
    logic [7:0]        img_q = 8'd0;
    logic              img_we;
    logic [7:0]        img_d;

    always #5 clk_sys = ~clk_sys;

    sim_sd_responder #(
        .VDNUM(2), .IMG_AW(24), .ACK_DELAY(4), .BYTE_GAP(1)
    ) dut (
        .clk_sys(clk_sys), .reset(reset),
        .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_lba(sd_lba),
        .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr),
        .sd_buff_dout(sd_buff_dout), .sd_buff_din(sd_buff_din),
        .sd_buff_wr(sd_buff_wr), .mount_strobe(mount_strobe),
        .mount_drive(mount_drive), .mount_size(mount_size),
        .mount_ro(mount_ro), .img_mounted(img_mounted),
        .img_size(img_size), .img_readonly(img_readonly),
        .img_drive(img_drive), .img_addr(img_addr), .img_rd(img_rd),
        .img_q(img_q), .img_we(img_we), .img_d(img_d)
    );

    int checks = 0;
    int failures = 0;
    int unsigned seed;

    // Image store: unwritten bytes follow a seeded pattern.
    logic [7:0] img [int];
    logic [7:0] wbuf [VDNUM][512];
    logic [7:0] din_q [VDNUM] = '{default: 8'd0};

    assign sd_buff_din = {din_q[1], din_q[0]};

    function automatic int ikey(int d, int a);
        return (d << 24) | a;
    endfunction

    function automatic logic [7:0] img_byte(int key);
        if (img.exists(key)) return img[key];
        return 8'((key * 37) ^ (key >> 9) ^ int'(seed));
    endfunction

    always @(posedge clk_sys) begin
        if (img_we) img[ikey(int'(img_drive), int'(img_addr))] = img_d;
        if (img_rd) img_q <= img_byte(ikey(int'(img_drive), int'(img_addr)));
        for (int n = 0; n < VDNUM; n++) din_q[n] <= wbuf[n][sd_buff_addr];
    end

    typedef struct {
        int cyc;
        int addr;
        int d;
        int ack;
    } stb_t;

    stb_t stq[$];
    int   rdq[$];
    int   n_we = 0;
    int   onehot_bad = 0;
    int   ack1_cyc = 0;
    int   ncyc = 0;

    always @(negedge clk_sys) begin
        ncyc++;
        if (sd_buff_wr)
            stq.push_back('{ncyc, int'(sd_buff_addr), int'(sd_buff_dout), int'(sd_ack)});
        if (img_rd) rdq.push_back(ikey(int'(img_drive), int'(img_addr)));
        if (img_we) n_we++;
        if ($countones(sd_ack) > 1) onehot_bad++;
        if (sd_ack[1]) ack1_cyc++;
    end

    task automatic step();
        @(negedge clk_sys);
        #1;
    endtask

    task automatic wait_ack(input int b, input logic lvl, input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            step();
            if (sd_ack[b] === lvl) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic do_mount(input int d, input logic [63:0] sz, input logic ro,
                            output logic [1:0] m1, output logic [1:0] m2);
        mount_drive  = 2'(d);
        mount_size   = sz;
        mount_ro     = ro;
        mount_strobe = 1'b1;
        step();
        mount_strobe = 1'b0;
        m1 = img_mounted;
        step();
        m2 = img_mounted;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        checks++;
        if (sd_ack !== 2'b00 || sd_buff_wr !== 1'b0 || sd_buff_addr !== 9'd0) begin
            failures++;
            $display("FAIL reset_hs ack=%0h wr=%0b addr=%0d expected 0", sd_ack, sd_buff_wr, sd_buff_addr);
        end
        checks++;
        if (img_mounted !== 2'b00 || img_size !== 64'd0 || img_readonly !== 1'b0) begin
            failures++;
            $display("FAIL reset_img mounted=%0h size=%0d ro=%0b expected 0", img_mounted, img_size, img_readonly);
        end
        checks++;
        if (img_rd !== 1'b0 || img_we !== 1'b0 || img_addr !== 24'd0 || img_drive !== 2'd0) begin
            failures++;
            $display("FAIL reset_port rd=%0b we=%0b addr=%0h drv=%0d expected 0", img_rd, img_we, img_addr, img_drive);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_read();
        logic [1:0] m1, m2;
        int n, s, a1, cnt, bad, gapbad;
        do_mount(0, 64'd4096, 1'b0, m1, m2);
        checks++;
        if (m1 !== 2'b01 || m2 !== 2'b00 || img_size !== 64'd4096) begin
            failures++;
            $display("FAIL mount0 pulse=%0b,%0b size=%0d expected 01,00 4096", m1, m2, img_size);
        end
        s = stq.size();
        a1 = ack1_cyc;
        sd_lba[31:0] = 32'd3;
        sd_rd[0] = 1'b1;
        wait_ack(0, 1'b1, 50, n);
        checks++;
        if (n != 5) begin
            failures++;
            $display("FAIL read_ack_latency got=%0d expected 5", n);
        end
        sd_rd[0] = 1'b0;
        wait_ack(0, 1'b0, 3000, n);
        checks++;
        if (n < 0) begin
            failures++;
            $display("FAIL read_ack_fall timeout expected ack fall");
        end
        cnt = stq.size() - s;
        checks++;
        if (cnt != 512) begin
            failures++;
            $display("FAIL read_strobes got=%0d expected 512", cnt);
        end
        bad = 0;
        gapbad = 0;
        for (int k = 0; k < cnt && k < 512; k++) begin
            if (stq[s+k].addr != k || stq[s+k].ack != 1 ||
                stq[s+k].d != int'(img_byte(ikey(0, 1536 + k)))) bad++;
            if (k > 0 && stq[s+k].cyc - stq[s+k-1].cyc != 3) gapbad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL read_data bad_bytes=%0d expected 0", bad);
        end
        checks++;
        if (gapbad != 0) begin
            failures++;
            $display("FAIL read_spacing bad_gaps=%0d expected 0", gapbad);
        end
        checks++;
        if (ack1_cyc != a1) begin
            failures++;
            $display("FAIL read_other_ack ack1_cycles=%0d expected 0", ack1_cyc - a1);
        end
    endtask

    task automatic test_burst();
        logic [1:0] m1, m2;
        int t, s, r, rises, extra, lowrun, lowmin, gaps, bad, starts;
        logic prev;
        do_mount(0, 64'd1 << 20, 1'b1, m1, m2);
        t = int'($urandom_range(0, 40));
        s = stq.size();
        r = rdq.size();
        sd_lba[31:0] = 32'(13 * t);
        sd_rd[0] = 1'b1;
        rises = 0;
        prev = 1'b0;
        lowrun = 0;
        lowmin = 1000;
        gaps = 0;
        for (int i = 0; i < 13 * 1700; i++) begin
            step();
            if (sd_ack[0] && !prev) begin
                rises++;
                if (rises > 1) begin
                    gaps++;
                    if (lowrun < lowmin) lowmin = lowrun;
                end
                sd_lba[31:0] = sd_lba[31:0] + 32'd1;
                if (rises == 13) sd_rd[0] = 1'b0;
            end
            if (!sd_ack[0]) lowrun = prev ? 1 : lowrun + 1;
            prev = sd_ack[0];
            if (rises >= 13 && !sd_ack[0]) break;
        end
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (sd_ack[0]) extra++;
        end
        checks++;
        if (rises != 13 || extra != 0) begin
            failures++;
            $display("FAIL burst_count pulses=%0d extra_high=%0d expected 13,0", rises, extra);
        end
        checks++;
        if (gaps != 12 || lowmin < 1) begin
            failures++;
            $display("FAIL burst_lowgap gaps=%0d min_low=%0d expected 12,>=1", gaps, lowmin);
        end
        starts = 0;
        bad = 0;
        for (int i = r; i < rdq.size(); i++) begin
            if ((rdq[i] & 511) == 0) begin
                if (rdq[i] != ikey(0, (13 * t + starts) * 512)) bad++;
                starts++;
            end
        end
        checks++;
        if (starts != 13 || bad != 0) begin
            failures++;
            $display("FAIL burst_lba sectors=%0d wrong_lba=%0d expected 13,0", starts, bad);
        end
        bad = 0;
        for (int k = 0; k < stq.size() - s; k++) begin
            if (stq[s+k].d != int'(img_byte(ikey(0, 13 * t * 512 + k)))) bad++;
        end
        checks++;
        if (stq.size() - s != 13 * 512 || bad != 0) begin
            failures++;
            $display("FAIL burst_data strobes=%0d bad=%0d expected 6656,0", stq.size() - s, bad);
        end
    endtask

    task automatic test_write();
        logic [1:0] m1, m2;
        int n, s, w, bad;
        do_mount(1, 64'd4096, 1'b0, m1, m2);
        for (int k = 0; k < 512; k++) wbuf[1][k] = 8'(k) ^ 8'h5A;
        s = stq.size();
        w = n_we;
        sd_lba[63:32] = 32'd0;
        sd_wr[1] = 1'b1;
        wait_ack(1, 1'b1, 50, n);
        sd_wr[1] = 1'b0;
        wait_ack(1, 1'b0, 3000, n);
        bad = 0;
        for (int k = 0; k < 512; k++)
            if (img_byte(ikey(1, k)) !== (8'(k) ^ 8'h5A)) bad++;
        checks++;
        if (n < 0 || bad != 0) begin
            failures++;
            $display("FAIL write_data fall=%0d bad_bytes=%0d expected done,0", n, bad);
        end
        checks++;
        if (stq.size() != s || n_we - w != 512) begin
            failures++;
            $display("FAIL write_strobes buff_wr=%0d img_we=%0d expected 0,512", stq.size() - s, n_we - w);
        end
        do_mount(1, 64'd4096, 1'b1, m1, m2);
        checks++;
        if (m1 !== 2'b10 || img_readonly !== 1'b1) begin
            failures++;
            $display("FAIL mount_ro pulse=%0b ro=%0b expected 10,1", m1, img_readonly);
        end
        for (int k = 0; k < 512; k++) wbuf[1][k] = 8'(k) ^ 8'hA5;
        w = n_we;
        sd_wr[1] = 1'b1;
        wait_ack(1, 1'b1, 50, n);
        sd_wr[1] = 1'b0;
        wait_ack(1, 1'b0, 3000, n);
        bad = 0;
        for (int k = 0; k < 512; k++)
            if (img_byte(ikey(1, k)) !== (8'(k) ^ 8'h5A)) bad++;
        checks++;
        if (n < 0 || bad != 0 || n_we != w) begin
            failures++;
            $display("FAIL write_ro fall=%0d changed=%0d img_we=%0d expected done,0,0", n, bad, n_we - w);
        end
    endtask

    task automatic test_oob();
        logic [1:0] m1, m2;
        int n, s, r, bad;
        do_mount(0, 64'd1000, 1'b0, m1, m2);
        s = stq.size();
        r = rdq.size();
        sd_lba[31:0] = 32'd1;
        sd_rd[0] = 1'b1;
        wait_ack(0, 1'b1, 50, n);
        sd_rd[0] = 1'b0;
        wait_ack(0, 1'b0, 3000, n);
        bad = 0;
        for (int k = 0; k < stq.size() - s; k++)
            if (stq[s+k].d != 0 || stq[s+k].addr != k) bad++;
        checks++;
        if (stq.size() - s != 512 || bad != 0) begin
            failures++;
            $display("FAIL oob_data strobes=%0d bad=%0d expected 512,0", stq.size() - s, bad);
        end
        checks++;
        if (rdq.size() != r) begin
            failures++;
            $display("FAIL oob_img_rd count=%0d expected 0", rdq.size() - r);
        end
    endtask

    task automatic test_contention();
        logic [1:0] m1, m2;
        int n, s, w, bad;
        do_mount(0, 64'd4096, 1'b0, m1, m2);
        do_mount(1, 64'd4096, 1'b0, m1, m2);
        for (int k = 0; k < 512; k++) wbuf[0][k] = 8'($urandom);
        sd_lba = {32'd6, 32'd5};
        s = stq.size();
        w = n_we;
        sd_rd[1] = 1'b1;
        sd_wr[0] = 1'b1;
        wait_ack(0, 1'b1, 50, n);
        checks++;
        if (n != 5 || sd_ack !== 2'b01) begin
            failures++;
            $display("FAIL contend_first latency=%0d ack=%0b expected 5,01", n, sd_ack);
        end
        sd_wr[0] = 1'b0;
        repeat (100) step();
        do_mount(1, 64'd143360, 1'b0, m1, m2);
        checks++;
        if (m1 !== 2'b10 || m2 !== 2'b00 || img_size !== 64'd143360 || sd_ack !== 2'b01) begin
            failures++;
            $display("FAIL midmount pulse=%0b,%0b size=%0d ack=%0b expected 10,00,143360,01",
                     m1, m2, img_size, sd_ack);
        end
        wait_ack(0, 1'b0, 3000, n);
        bad = 0;
        for (int k = 0; k < 512; k++)
            if (img_byte(ikey(0, 5 * 512 + k)) !== wbuf[0][k]) bad++;
        checks++;
        if (n < 0 || bad != 0 || n_we - w != 512 || stq.size() != s) begin
            failures++;
            $display("FAIL contend_write fall=%0d bad=%0d img_we=%0d buff_wr=%0d expected done,0,512,0",
                     n, bad, n_we - w, stq.size() - s);
        end
        wait_ack(1, 1'b1, 50, n);
        sd_rd[1] = 1'b0;
        wait_ack(1, 1'b0, 3000, n);
        bad = 0;
        for (int k = 0; k < stq.size() - s; k++)
            if (stq[s+k].ack != 2 || stq[s+k].d != int'(img_byte(ikey(1, 6 * 512 + k)))) bad++;
        checks++;
        if (n < 0 || stq.size() - s != 512 || bad != 0) begin
            failures++;
            $display("FAIL contend_read fall=%0d strobes=%0d bad=%0d expected done,512,0",
                     n, stq.size() - s, bad);
        end
        checks++;
        if (onehot_bad != 0) begin
            failures++;
            $display("FAIL ack_onehot multi_cycles=%0d expected 0", onehot_bad);
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0] m1, m2;
        int n, s, bad, guard;
        do_mount(0, 64'd4096, 1'b0, m1, m2);
        s = stq.size();
        sd_lba[31:0] = 32'd2;
        sd_rd[0] = 1'b1;
        guard = 0;
        while (stq.size() - s < 200 && guard < 2000) begin
            step();
            guard++;
        end
        checks++;
        if (stq.size() - s != 200) begin
            failures++;
            $display("FAIL rst_reach strobes=%0d expected 200", stq.size() - s);
        end
        reset = 1'b1;
        step();
        checks++;
        if (sd_ack !== 2'b00 || sd_buff_wr !== 1'b0 || img_rd !== 1'b0 || img_size !== 64'd0) begin
            failures++;
            $display("FAIL rst_mid ack=%0b wr=%0b img_rd=%0b size=%0d expected 0",
                     sd_ack, sd_buff_wr, img_rd, img_size);
        end
        reset = 1'b0;
        s = stq.size();
        wait_ack(0, 1'b1, 50, n);
        checks++;
        if (n != 5) begin
            failures++;
            $display("FAIL rst_restart latency=%0d expected 5", n);
        end
        sd_rd[0] = 1'b0;
        wait_ack(0, 1'b0, 3000, n);
        bad = 0;
        for (int k = 0; k < stq.size() - s; k++)
            if (stq[s+k].addr != k || stq[s+k].d != 0) bad++;
        checks++;
        if (n < 0 || stq.size() - s != 512 || bad != 0) begin
            failures++;
            $display("FAIL rst_fresh fall=%0d strobes=%0d bad=%0d expected done,512,0",
                     n, stq.size() - s, bad);
        end
    endtask

    initial begin
        seed = $urandom;
        for (int n = 0; n < VDNUM; n++)
            for (int k = 0; k < 512; k++) wbuf[n][k] = 8'd0;
        test_reset();
        test_read();
        test_burst();
        test_write();
        test_oob();
        test_contention();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sim_sd_responder.md
Name: sim_sd_responder

Overview:
- Simulation-side model of the host's SD/virtual-disk service for the emu wrapper: it is the responder end of the sd_rd/sd_wr/sd_ack/sd_buff_* sector handshake that the floppy and HDD loaders drive.
- Accepts sector requests from up to VDNUM virtual drives and streams 512-byte sectors between a backing image-store port and the requester's sector buffer.
- Generates img_mounted/img_size/img_readonly on mount events.

Parameters:
- VDNUM, 2, number of virtual drives (1..4).
- IMG_AW, 24, byte-address width of the image-store port.
- ACK_DELAY, 4, cycles from request acceptance to sd_ack rise (>=1).
- BYTE_GAP, 1, idle cycles after each byte transfer (>=0).

Ports:
- clk_sys  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- sd_rd  in  VDNUM  per-drive read request, level.
- sd_wr  in  VDNUM  per-drive write request, level.
- sd_lba  in  32*VDNUM  per-drive LBA; drive n uses bits [32n+31:32n].
- sd_ack  out  VDNUM  per-drive acknowledge; high for the whole transfer.
- sd_buff_addr  out  9  byte index within the sector.
- sd_buff_dout  out  8  read data to the requester.
- sd_buff_din  in  8*VDNUM  write data from the requester, per drive.
- sd_buff_wr  out  1  one-cycle strobe; sd_buff_dout is valid at sd_buff_addr.
- mount_strobe  in  1  one-cycle mount event.
- mount_drive  in  2  drive index for the mount event.
- mount_size  in  64  image size in bytes; 0 means eject.
- mount_ro  in  1  read-only flag for the mount event.
- img_mounted  out  VDNUM  one-cycle pulse per mounted drive.
- img_size  out  64  size from the last mount; held.
- img_readonly  out  1  read-only flag from the last mount; held.
- img_drive  out  2  image-store drive select.
- img_addr  out  IMG_AW  image byte address = {lba, index}, truncated.
- img_rd  out  1  image read strobe; img_q is valid the next cycle.
- img_q  in  8  image read data.
- img_we  out  1  image write strobe.
- img_d  out  8  image write data.

Behaviour:
- Reset: every output is 0; FSM goes to IDLE; all per-drive size/ro registers are 0. Reset mid-transfer abandons the transfer at the next edge; bytes already written to the image stay written.
- Mount: on mount_strobe, with mount_drive < VDNUM, at the next edge:
  - latch size_n and ro_n;
  - img_size <= mount_size; img_readonly <= mount_ro;
  - img_mounted[mount_drive] pulses high for exactly 1 cycle.
  - Mount events are accepted in any FSM state. An in-flight transfer keeps the size/ro it latched at acceptance.
- IDLE: scan drives from 0 upward; the first with sd_rd|sd_wr wins.
  - Latch drive, op (read if sd_rd, else write; read wins if both are high), lba, size_n and ro_n.
  - Go to ACKWAIT.
- Sector validity: valid iff zero-extended lba < size[63:9]. Partial trailing sectors are invalid.
- ACKWAIT: count ACK_DELAY cycles, then set sd_ack[drive]=1, index=0, and go to the op state.
- Read, per byte:
  - RD_FETCH: img_rd=1, img_addr={lba,index}.
  - RD_PUT, next cycle: sd_buff_addr=index; sd_buff_dout=img_q, or 0 if the sector is invalid; sd_buff_wr=1 for exactly 1 cycle.
  - Then BYTE_GAP idle cycles.
  - Cost: 2+BYTE_GAP cycles per byte. img_rd is suppressed when the sector is invalid.
- Write, per byte:
  - WR_ADDR: sd_buff_addr=index.
  - WR_WAIT: one cycle.
  - WR_CAP: capture sd_buff_din[drive] (requester buffer has 1-cycle registered latency); pulse img_we=1 with img_d and img_addr={lba,index}. img_we is suppressed if the sector is invalid or ro_n is set.
  - Then BYTE_GAP idle cycles. sd_buff_wr stays 0 throughout a write.
- After index 511 completes: go to DONE.
  - DONE: sd_ack=0, sd_buff_wr=0; next state IDLE.
  - IDLE must last at least 1 cycle before the next acceptance, so sd_ack always shows a falling edge followed by a low cycle.
- Requests are level-sensitive. A requester that holds sd_rd high after ack falls gets another sector, using the sd_lba value sampled at the new acceptance. The floppy loader relies on this for 13 consecutive sectors.
- Request inputs for the active drive are ignored between acceptance and DONE, including a deassert mid-transfer.
- index is a 9-bit counter; it never wraps within a sector and is terminated at 511.
- Only one sd_ack bit is ever high at a time.

Test Plan:
- Read drive 0, lba=3, size=4096 (BYTE_GAP=1, ACK_DELAY=4) -> sd_ack[0] rises 5 cycles after sd_rd; 512 sd_buff_wr pulses spaced 3 cycles apart; byte k equals image[1536+k]; ack falls; no other ack bit toggles.
- Floppy-style burst: sd_rd[0] held high, lba incremented on each ack rise, requester drops sd_rd on the 13th ack rise -> exactly 13 ack pulses with lbas 13t..13t+12 in order and >=1 low cycle between pulses.
- Write drive 1, lba=0, requester buffer byte k = k^0x5A -> image[k] = k^0x5A for k=0..511; sd_buff_wr never asserted; mounted ro=1 repeat -> image unchanged, handshake still completes.
- Out-of-range read: size=1000, lba=1 -> 512 strobes with sd_buff_dout=0, img_rd never asserted.
- Contention and mount: sd_rd[1] and sd_wr[0] rise on the same cycle -> drive 0 is served first, then drive 1; mount_strobe (drive 1, size 143360, ro 0) mid-transfer -> img_mounted=2'b10 for 1 cycle, img_size=143360, and the transfer completes unaffected.
- Reset asserted at byte 200 of a read -> next cycle sd_ack=0, sd_buff_wr=0, FSM in IDLE; with sd_rd still high after release, a fresh full 512-byte transfer starts from index 0.
